// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : Transmit-side UART with a small byte FIFO and an 8N1 serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [BAUD_W-1:0]  r_baud, w_baud_next;
    logic [2:0]         r_bit, w_bit_next;
    logic [7:0]         r_shift, w_shift_next;
    logic               r_txd, w_txd_next;
    logic               w_push, w_pop, w_last;
    logic [7:0]         w_head;

    assign wr_ready   = (r_count != C_FULL);
    assign w_push     = wr_valid && wr_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_last     = (r_baud == C_BAUD_LAST);
    assign TXD        = r_txd;
    assign fifo_count = r_count;
    assign busy       = (r_state != IDLE) || (r_count != '0);

    // Storage carries no reset: occupancy is governed by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_txd    <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_txd    <= w_txd_next;
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // TXD is computed one edge ahead so the registered line matches the state.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_baud_next  = w_last ? '0 : r_baud + BAUD_W'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_txd_next   = r_txd;

        case (r_state)
            IDLE: begin
                w_txd_next  = 1'b1;
                w_baud_next = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_txd_next   = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                w_txd_next = 1'b0;
                if (w_last) begin
                    w_bit_next   = 3'd0;
                    w_txd_next   = r_shift[0];
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    if (r_bit == 3'd7) begin
                        w_txd_next   = 1'b1;
                        w_state_next = STOP;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = r_shift >> 1;
                        w_txd_next   = r_shift[1];
                    end
                end
            end
            STOP: begin
                w_txd_next = 1'b1;
                if (w_last) begin
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_txd_next   = 1'b0;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Brief    : Directed bench for uart_tx_ctrl with hand-derived expected frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       w_wr_ready;
    logic       w_txd;
    logic       w_busy;
    logic [2:0] w_fifo_count;

    int n_total;
    int n_bad;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_dut (
        .CLK        (clk),
        .RESET      (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (w_wr_ready),
        .TXD        (w_txd),
        .busy       (w_busy),
        .fifo_count (w_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c of a frame (0..39): start bit, 8 data bits LSB first, stop bit.
    task automatic expect_frame(input logic [7:0] b, input int first, input int exp_cnt);
        int   bitn;
        logic expb;
        for (int c = first; c < 40; c++) begin
            tick();
            bitn = c / CLKS_PER_BIT;
            if (bitn == 0)      expb = 1'b0;
            else if (bitn == 9) expb = 1'b1;
            else                expb = b[bitn-1];
            check_val("txd_frame", {31'd0, w_txd}, {31'd0, expb});
            if (c == first && exp_cnt >= 0) begin
                check_val("cnt_frame_start", {29'd0, w_fifo_count}, exp_cnt);
            end
        end
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tick();
        tick();
        check_val("rst_txd",   {31'd0, w_txd},      32'd1);
        check_val("rst_busy",  {31'd0, w_busy},     32'd0);
        check_val("rst_ready", {31'd0, w_wr_ready}, 32'd1);
        check_val("rst_cnt",   {29'd0, w_fifo_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Single 0x55 frame into an idle block.
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        wr_data  = 8'hEE;
        check_val("t1_cnt_accept", {29'd0, w_fifo_count}, 32'd1);
        check_val("t1_txd_accept", {31'd0, w_txd}, 32'd1);
        check_val("t1_busy_accept", {31'd0, w_busy}, 32'd1);
        expect_frame(8'h55, 0, -1);
        tick();
        check_val("t1_idle_txd",  {31'd0, w_txd},  32'd1);
        check_val("t1_idle_busy", {31'd0, w_busy}, 32'd0);

        // Three back-to-back frames.
        wr_valid = 1'b1;
        wr_data  = 8'hA3;
        tick();
        check_val("t2_cnt0", {29'd0, w_fifo_count}, 32'd1);
        wr_data = 8'h0F;
        tick();
        check_val("t2_cnt1", {29'd0, w_fifo_count}, 32'd1);
        check_val("t2_txd1", {31'd0, w_txd}, 32'd0);
        wr_data = 8'hFF;
        tick();
        check_val("t2_cnt2", {29'd0, w_fifo_count}, 32'd2);
        wr_valid = 1'b0;
        expect_frame(8'hA3, 2, -1);
        expect_frame(8'h0F, 0, 1);
        expect_frame(8'hFF, 0, 0);
        tick();
        check_val("t2_idle_txd",  {31'd0, w_txd},  32'd1);
        check_val("t2_idle_busy", {31'd0, w_busy}, 32'd0);

        // Streaming writes fill the FIFO; STOP-end pop collides with a blocked write.
        wr_valid = 1'b1;
        wr_data  = 8'h01;
        tick();
        check_val("t3_cnt_n0", {29'd0, w_fifo_count}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            wr_data = 8'(k + 1);
            tick();
            check_val("t3_txd_start", {31'd0, w_txd}, 32'd0);
            check_val("t3_cnt_fill", {29'd0, w_fifo_count}, (k == 1) ? 32'd1 : 32'(k));
        end
        wr_data = 8'h06;
        check_val("t3_ready_full", {31'd0, w_wr_ready}, 32'd0);
        expect_frame(8'h01, 4, -1);
        check_val("t3_cnt_full_end", {29'd0, w_fifo_count}, 32'd4);
        check_val("t3_ready_full_end", {31'd0, w_wr_ready}, 32'd0);
        tick();
        check_val("t4_cnt_pop", {29'd0, w_fifo_count}, 32'd3);
        check_val("t4_ready_pop", {31'd0, w_wr_ready}, 32'd1);
        check_val("t4_txd_pop", {31'd0, w_txd}, 32'd0);
        tick();
        wr_valid = 1'b0;
        wr_data  = 8'h99;
        check_val("t4_cnt_refill", {29'd0, w_fifo_count}, 32'd4);
        check_val("t4_ready_refill", {31'd0, w_wr_ready}, 32'd0);
        expect_frame(8'h02, 2, -1);
        expect_frame(8'h03, 0, 3);
        expect_frame(8'h04, 0, 2);
        expect_frame(8'h05, 0, 1);
        expect_frame(8'h06, 0, 0);
        tick();
        check_val("t3_idle_busy", {31'd0, w_busy}, 32'd0);

        // Reset in the middle of data bit 3 with two bytes queued.
        wr_valid = 1'b1;
        wr_data  = 8'h30;
        tick();
        wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_valid = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        check_val("t5_txd_bit3", {31'd0, w_txd}, 32'd0);
        check_val("t5_cnt_pre", {29'd0, w_fifo_count}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_txd",   {31'd0, w_txd},      32'd1);
        check_val("t5_busy",  {31'd0, w_busy},     32'd0);
        check_val("t5_cnt",   {29'd0, w_fifo_count}, 32'd0);
        check_val("t5_ready", {31'd0, w_wr_ready}, 32'd1);

        // Quiet line after reset: no leftover frame appears.
        for (int k = 0; k < 200; k++) begin
            tick();
            check_val("t6_idle", {30'd0, w_txd, w_busy}, 32'd2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
